ysyx_22051086_axi_rd_arbiter: RTL
=================================

YSYX_22051086_AXI_RD_ARBITER -- requirements
Module: ysyx_22051086_axi_rd_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, AXI address width.
REQ-002 Parameter: DATA_W, 64, AXI read data width.
REQ-003 Prefix rules: {i,d}_ = ICACHE/DCACHE master-side port; s_ = slave-side port to ysyx_22051086_SRAM, with direction opposite to the master side.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 {i,d}_araddr in ADDR_W / s_araddr out ADDR_W  read burst start address.
REQ-007 {i,d}_arlen in 4 / s_arlen out 4  beats minus 1.
REQ-008 {i,d}_arsize in 3 / s_arsize out 3  beat size.
REQ-009 {i,d}_arburst in 2 / s_arburst out 2  burst type.
REQ-010 {i,d}_arvalid in 1 / s_arvalid out 1  AR request valid.
REQ-011 {i,d}_arready out 1 / s_arready in 1  AR accepted.
REQ-012 {i,d}_rdata out DATA_W / s_rdata in DATA_W  read beat data.
REQ-013 {i,d}_rresp out 2 / s_rresp in 2  beat response.
REQ-014 {i,d}_rlast out 1 / s_rlast in 1  final beat.
REQ-015 {i,d}_rvalid out 1 / s_rvalid in 1  beat valid.
REQ-016 {i,d}_rready in 1 / s_rready out 1  beat accept.
REQ-017 grant  out  2  one-hot owner: bit0 = ICACHE, bit1 = DCACHE; 00 when no master owns the slave.
REQ-018 err  out  1  sticky burst-length violation flag.

Function
REQ-019 FSM states: IDLE, AR, R; owner register own (I/D); last-served register last (I/D).
REQ-020 IDLE: any {i,d}_arvalid -> AR, load own; single requester wins; if both request, the master != last wins.
REQ-021 AR: s_ar* = owner's ar* (combinational mux); s_arvalid = owner arvalid; owner arready = s_arready; non-owner arready = 0; on s_arvalid&&s_arready -> R, latch arlen into len_q, clear beat counter, set last = own.
REQ-022 R: owner r* = s_r*, s_rready = owner rready; non-owner rvalid = 0; each s_rvalid&&s_rready increments 4-bit beat counter; on handshake with s_rlast -> IDLE.
REQ-023 In IDLE and R: s_arvalid = 0, {i,d}_arready = 0; in IDLE and AR: s_rready = 0, {i,d}_rvalid = 0.
REQ-024 Arbitration latency: exactly 1 cycle from arvalid rising in IDLE to s_arvalid high; back-to-back bursts are separated by one IDLE cycle.
REQ-025 Ownership is held for the whole burst; a request from the other master is not accepted before rlast, and that master's arvalid stays pending.
REQ-026 grant = one-hot(own) in AR and R; 00 in IDLE.
REQ-027 err sets when rlast is handshaken with beat != len_q, or when a beat is handshaken with beat == len_q but without rlast; err clears only on reset.
REQ-028 Beat counter saturates at 15; no wrap-around.
REQ-029 Non-owner arvalid changing during AR or R has no effect on any output.

Reset
REQ-030 While rst is high (asynchronous): state = IDLE, last = I (first tie goes to DCACHE), own = I, beat = 0, len_q = 0, err = 0, grant = 00, s_arvalid = 0, s_rready = 0, all master arready/rvalid = 0.
REQ-031 Reset asserted mid-burst aborts the burst immediately; the slave is expected to be reset by the same rst.

Verification
REQ-032 ICACHE-only request, araddr 0x80000020, arlen 3: s_arvalid high 1 cycle after i_arvalid, grant = 01, 4 beats reach i_rdata, d_rvalid = 0 throughout, returns to IDLE after beat 4, err = 0.
REQ-033 Both masters request on the first cycle after reset: DCACHE is served first (grant = 10); ICACHE is granted in the cycle after DCACHE's rlast handshake plus one IDLE cycle.
REQ-034 Both masters request continuously: grants alternate D, I, D, I over 4 bursts.
REQ-035 s_arready held low for 5 cycles: owner arready = 0 and FSM stays in AR; owner s_ar* fields stable; acceptance occurs on the cycle s_arready rises.
REQ-036 arlen 3 with slave asserting rlast on beat 2: err = 1, FSM returns to IDLE, err stays 1 through later clean bursts.
REQ-037 rst pulsed during R beat 2: all outputs reach reset values without waiting for a clock edge; a subsequent ICACHE request completes normally.

Source files
------------

// File: rtl/ysyx_22051086_axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter: ICACHE and DCACHE share one SRAM read port.
// Whole-burst ownership, alternating priority on ties, sticky burst-length error flag.
module ysyx_22051086_axi_rd_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    // ICACHE master
    input  logic [ADDR_W-1:0] i_araddr,
    input  logic [3:0]        i_arlen,
    input  logic [2:0]        i_arsize,
    input  logic [1:0]        i_arburst,
    input  logic              i_arvalid,
    output logic              i_arready,
    output logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        i_rresp,
    output logic              i_rlast,
    output logic              i_rvalid,
    input  logic              i_rready,
    // DCACHE master
    input  logic [ADDR_W-1:0] d_araddr,
    input  logic [3:0]        d_arlen,
    input  logic [2:0]        d_arsize,
    input  logic [1:0]        d_arburst,
    input  logic              d_arvalid,
    output logic              d_arready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [1:0]        d_rresp,
    output logic              d_rlast,
    output logic              d_rvalid,
    input  logic              d_rready,
    // SRAM slave
    output logic [ADDR_W-1:0] s_araddr,
    output logic [3:0]        s_arlen,
    output logic [2:0]        s_arsize,
    output logic [1:0]        s_arburst,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rlast,
    input  logic              s_rvalid,
    output logic              s_rready,
    // status
    output logic [1:0]        grant,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, AR, R} state_t;

    localparam logic SEL_I = 1'b0;
    localparam logic SEL_D = 1'b1;
    localparam logic [3:0] BEAT_MAX = 4'hF;

    state_t     state_q, state_d;
    logic       own_q, own_d;
    logic       last_q, last_d;
    logic [3:0] beat_q, beat_d;
    logic [3:0] len_q, len_d;
    logic       err_q, err_d;

    logic       own_arvalid;
    logic       own_rready;
    logic       ar_hs;
    logic       r_hs;

    // State and bookkeeping registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            own_q   <= SEL_I;
            last_q  <= SEL_I;
            beat_q  <= 4'd0;
            len_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // Next-state, channel muxing and handshake routing
    always_comb begin
        state_d   = state_q;
        own_d     = own_q;
        last_d    = last_q;
        beat_d    = beat_q;
        len_d     = len_q;
        err_d     = err_q;

        own_arvalid = (own_q == SEL_D) ? d_arvalid : i_arvalid;
        own_rready  = (own_q == SEL_D) ? d_rready  : i_rready;

        s_araddr  = (own_q == SEL_D) ? d_araddr  : i_araddr;
        s_arlen   = (own_q == SEL_D) ? d_arlen   : i_arlen;
        s_arsize  = (own_q == SEL_D) ? d_arsize  : i_arsize;
        s_arburst = (own_q == SEL_D) ? d_arburst : i_arburst;
        s_arvalid = 1'b0;
        s_rready  = 1'b0;
        i_arready = 1'b0;
        d_arready = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;

        // R payload is broadcast; only rvalid selects the recipient
        i_rdata = s_rdata;
        i_rresp = s_rresp;
        i_rlast = s_rlast;
        d_rdata = s_rdata;
        d_rresp = s_rresp;
        d_rlast = s_rlast;

        case (state_q)
            IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    state_d = AR;
                    if (i_arvalid && d_arvalid) own_d = ~last_q;
                    else                        own_d = d_arvalid ? SEL_D : SEL_I;
                end
            end
            AR: begin
                s_arvalid = own_arvalid;
                i_arready = (own_q == SEL_I) && s_arready;
                d_arready = (own_q == SEL_D) && s_arready;
                ar_hs     = own_arvalid && s_arready;
                if (ar_hs) begin
                    state_d = R;
                    len_d   = s_arlen;
                    beat_d  = 4'd0;
                    last_d  = own_q;
                end
            end
            R: begin
                s_rready = own_rready;
                i_rvalid = (own_q == SEL_I) && s_rvalid;
                d_rvalid = (own_q == SEL_D) && s_rvalid;
                r_hs     = s_rvalid && own_rready;
                if (r_hs) begin
                    if (beat_q != BEAT_MAX) beat_d = beat_q + 4'd1;
                    // rlast must coincide exactly with the beat numbered len_q
                    if (s_rlast != (beat_q == len_q)) err_d = 1'b1;
                    if (s_rlast) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = (state_q == IDLE) ? 2'b00 : ((own_q == SEL_D) ? 2'b10 : 2'b01);
    assign err   = err_q;

endmodule
